// File: rtl/md5_core_scheduler_if.sv
// Scheduler <-> MD5 core link: start/word toward the core, ready/valid/digest back.
interface md5_core_scheduler_if #(
    parameter int WORD_W = 128,
    parameter int HASH_W = 128
);
    logic              core_ready;
    logic              core_start;
    logic [WORD_W-1:0] core_word;
    logic [7:0]        core_word_width;
    logic              core_valid;
    logic [HASH_W-1:0] core_hash;

    modport master (
        input  core_ready, core_valid, core_hash,
        output core_start, core_word, core_word_width
    );

    modport slave (
        output core_ready, core_valid, core_hash,
        input  core_start, core_word, core_word_width
    );
endinterface

// File: rtl/md5_core_scheduler.sv
// Round-robin arbiter that feeds one MD5 core from N_REQ candidate generators
// and latches the first candidate whose digest equals target_hash.
module md5_core_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = 128,
    parameter int HASH_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_word,
    input  logic [N_REQ*8-1:0]      req_width,
    output logic [N_REQ-1:0]        req_ack,
    input  logic [HASH_W-1:0]       target_hash,
    input  logic                    clear,
    md5_core_scheduler_if.master    core,
    output logic                    busy,
    output logic                    found,
    output logic [WORD_W-1:0]       found_word,
    output logic [2:0]              found_id,
    output logic [31:0]             hash_count,
    output logic                    timeout_err
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, FOUND} state_t;

    state_t            state_q;
    logic [IDW-1:0]    last_q;
    logic [IDW-1:0]    cur_id_q;
    logic [CW-1:0]     wait_q;
    logic [HASH_W-1:0] hash_q;
    logic [WORD_W-1:0] word_q;
    logic [7:0]        width_q;
    logic              start_q;
    logic              busy_q;
    logic              found_q;
    logic [WORD_W-1:0] found_word_q;
    logic [2:0]        found_id_q;
    logic [31:0]       count_q;
    logic              terr_q;

    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic              grant;

    // First valid requester scanning upward from the one after the last grant.
    always_comb begin
        cand    = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDW'((int'(last_q) + off) % N_REQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = (state_q == IDLE) && core.core_ready && gnt_any;

    always_comb begin
        req_ack = '0;
        if (grant) begin
            req_ack = N_REQ'(1) << gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_q       <= IDW'(N_REQ - 1);
            cur_id_q     <= '0;
            wait_q       <= '0;
            hash_q       <= '0;
            word_q       <= '0;
            width_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            found_word_q <= '0;
            found_id_q   <= '0;
            count_q      <= '0;
            terr_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        word_q   <= req_word[int'(gnt_idx)*WORD_W +: WORD_W];
                        width_q  <= req_width[int'(gnt_idx)*8 +: 8];
                        cur_id_q <= gnt_idx;
                        last_q   <= gnt_idx;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A digest arriving on the final counted cycle still wins over the timeout.
                    if (core.core_valid) begin
                        hash_q  <= core.core_hash;
                        state_q <= COMPARE;
                    end else if (wait_q == CW'(TIMEOUT - 1)) begin
                        terr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                COMPARE: begin
                    if (count_q != '1) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (hash_q == target_hash) begin
                        found_q      <= 1'b1;
                        found_word_q <= word_q;
                        found_id_q   <= 3'(cur_id_q);
                        state_q      <= FOUND;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                FOUND: begin
                    if (clear) begin
                        found_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core.core_start      = start_q;
    assign core.core_word       = word_q;
    assign core.core_word_width = width_q;
    assign busy                 = busy_q;
    assign found                = found_q;
    assign found_word           = found_word_q;
    assign found_id             = found_id_q;
    assign hash_count           = count_q;
    assign timeout_err          = terr_q;

endmodule
